// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bridge.
// State encodings, bus width and the default timeout limit.
package dmem_bridge_pkg;

  localparam int REG_BUS         = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic word_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter that flags a bus access running past LIMIT cycles.
// Only instantiated when DMEM_BRIDGE_TIMEOUT_EN is defined.
module dmem_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // expire fires in the LIMIT-th enabled cycle, so the count saturates there
  assign expire = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-port to req/ack bus bridge with pipeline stall and error flag.
// Optional bus timeout: define DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W      = REG_BUS,
  parameter int DATA_W      = REG_BUS,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  if (TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("dmem_bridge: TIMEOUT_CYC must be at least 1");
  end

  state_t state;
  state_t state_nxt;

  logic access;
  logic aligned;
  logic tmo_expire;

  assign access  = cpu_MemRead | cpu_MemWrite;
  assign aligned = word_aligned(cpu_addr[1:0]);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != BUS),
    .enable (state == BUS),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = access;
        if (access) begin
          state_nxt = aligned ? BUS : DONE;
        end
      end
      BUS: begin
        stall = 1'b1;
        if (bus_ack || tmo_expire) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= cpu_MemWrite;
            bus_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= cpu_wdata;
          end else if (access) begin
            cpu_rdata <= '0;
            err       <= 1'b1;
          end
        end
        BUS: begin
          // an ack in the same cycle as expiry still completes normally
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              cpu_rdata <= bus_rdata;
            end
          end else if (tmo_expire) begin
            bus_req   <= 1'b0;
            cpu_rdata <= '0;
            err       <= 1'b1;
          end
        end
        DONE: begin
          err <= 1'b0;
        end
        default: begin
          err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized self-checking bench for dmem_bridge.
// Honors DMEM_BRIDGE_TIMEOUT_EN when the bundle is built with it.
`timescale 1ns/1ps
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_MemRead = 1'b0;
  logic        cpu_MemWrite = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  dmem_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_MemRead  (cpu_MemRead),
    .cpu_MemWrite (cpu_MemWrite),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .err          (err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  // Expected BUS-phase length from the access rules.
  function automatic int exp_reqs(input bit mis, input int delay);
    if (mis) return 0;
    if (TMO_EN && (delay == 0 || delay > TMO)) return TMO;
    return delay;
  endfunction

  function automatic bit exp_tmo(input bit mis, input int delay);
    return !mis && TMO_EN && (delay == 0 || delay > TMO);
  endfunction

  // Plays the core and memory for one access; called at #1 after posedge.
  task automatic run_access(
    input  bit          rd,
    input  bit          wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] ack_dat,
    input  int          delay,
    input  int          max_cyc,
    output int          stalls,
    output int          reqs,
    output bit          errs,
    output logic [31:0] rdat,
    output bit          stable,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output bit          finished
  );
    stalls = 0; reqs = 0; errs = 0; rdat = '0; stable = 1;
    we_o = 0; addr_o = '0; wdata_o = '0; finished = 0;
    cpu_MemRead = rd; cpu_MemWrite = wr;
    cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!stall) begin
        errs = err; rdat = cpu_rdata; finished = 1;
        break;
      end
      stalls++;
      if (err) errs = 1;
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          we_o = bus_we; addr_o = bus_addr; wdata_o = bus_wdata;
        end else if (bus_we !== we_o || bus_addr !== addr_o ||
                     bus_wdata !== wdata_o) begin
          stable = 0;
        end
        if (reqs == delay) begin
          bus_ack = 1'b1; bus_rdata = ack_dat;
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    if (finished) begin
      @(posedge clk); #1;
    end
    cpu_MemRead = 0; cpu_MemWrite = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, err, stall} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h rd=%h err=%b stall=%b, want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, err, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_imm;
    int st, rq; bit e, sb, fin; logic w; logic [31:0] rd, a, wd;
    run_access(1, 0, 32'h10, 32'h0, 32'h1234_5678, 1, 50,
               st, rq, e, rd, sb, w, a, wd, fin);
    total++;
    if (st !== 2 || !fin) begin bad++; $display("FAIL load_imm_stall: got %0d want 2", st); end
    total++;
    if (rd !== 32'h1234_5678) begin bad++; $display("FAIL load_imm_rdata: got %h want 12345678", rd); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL load_imm_err: got %b want 0", e); end
    total++;
    if (w !== 1'b0 || a !== 32'h10) begin bad++; $display("FAIL load_imm_bus: we=%b addr=%h want 0/10", w, a); end
    last_rdata = 32'h1234_5678;
  endtask

  task automatic test_store_delayed;
    int st, rq; bit e, sb, fin, t; logic w; logic [31:0] rd, a, wd;
    t = exp_tmo(0, 5);
    run_access(0, 1, 32'h20, 32'hCAFE_F00D, 32'h0, 5, 50,
               st, rq, e, rd, sb, w, a, wd, fin);
    total++;
    if (st !== exp_reqs(0, 5) + 1) begin bad++; $display("FAIL store_stall: got %0d want %0d", st, exp_reqs(0, 5) + 1); end
    total++;
    if (rq !== exp_reqs(0, 5)) begin bad++; $display("FAIL store_reqs: got %0d want %0d", rq, exp_reqs(0, 5)); end
    total++;
    if (!sb || w !== 1'b1 || a !== 32'h20 || wd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL store_bus: stable=%b we=%b addr=%h wd=%h", sb, w, a, wd);
    end
    total++;
    if (e !== t) begin bad++; $display("FAIL store_err: got %b want %b", e, t); end
    if (t) last_rdata = '0;
    total++;
    if (rd !== last_rdata) begin bad++; $display("FAIL store_rdata: got %h want %h", rd, last_rdata); end
  endtask

  task automatic test_misaligned;
    int st, rq; bit e, sb, fin; logic w; logic [31:0] rd, a, wd;
    run_access(1, 0, 32'h13, 32'h0, 32'h0, 1, 50,
               st, rq, e, rd, sb, w, a, wd, fin);
    total++;
    if (rq !== 0 || st !== 1) begin bad++; $display("FAIL mis_timing: reqs=%0d stalls=%0d want 0/1", rq, st); end
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_err: err=%b rdata=%h want 1/0", e, rd); end
    last_rdata = '0;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_exit: err=%b stall=%b want 0/0", err, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_stray_ack;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || cpu_rdata !== last_rdata) begin
      bad++; $display("FAIL stray_ack: req=%b stall=%b rdata=%h want 0/0/%h", bus_req, stall, cpu_rdata, last_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both_strobes;
    int st, rq; bit e, sb, fin; logic w; logic [31:0] rd, a, wd, d;
    d = $urandom;
    run_access(1, 1, 32'h40, d, 32'h5555_AAAA, 2, 50,
               st, rq, e, rd, sb, w, a, wd, fin);
    total++;
    if (w !== 1'b1 || a !== 32'h40 || wd !== d) begin bad++; $display("FAIL both_bus: we=%b addr=%h wd=%h want 1/40/%h", w, a, wd, d); end
    total++;
    if (rq !== 2 || e !== 1'b0 || rd !== last_rdata) begin
      bad++; $display("FAIL both_result: reqs=%0d err=%b rdata=%h want 2/0/%h", rq, e, rd, last_rdata);
    end
  endtask

  task automatic test_reset_mid;
    cpu_MemRead = 1'b1; cpu_addr = 32'h80;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_before: got %b want 1", bus_req); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL rstmid_req_drop: got %b want 0", bus_req); end
    cpu_MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, err, stall} !== '0) begin
      bad++; $display("FAIL rstmid_idle: req=%b we=%b addr=%h rd=%h err=%b stall=%b want all 0",
                      bus_req, bus_we, bus_addr, cpu_rdata, err, stall);
    end
    last_rdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int st, rq; bit e, sb, fin; logic w; logic [31:0] rd, a, wd;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    run_access(1, 0, 32'h100, 32'h0, 32'h0, 0, 50,
               st, rq, e, rd, sb, w, a, wd, fin);
    total++;
    if (!fin || rq !== TMO || st !== TMO + 1) begin
      bad++; $display("FAIL timeout_len: fin=%b reqs=%0d stalls=%0d want 1/%0d/%0d", fin, rq, st, TMO, TMO + 1);
    end
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL timeout_err: err=%b rdata=%h want 1/0", e, rd); end
    last_rdata = '0;
`else
    run_access(1, 0, 32'h100, 32'h0, 32'h0, 0, 100,
               st, rq, e, rd, sb, w, a, wd, fin);
    @(negedge clk);
    total++;
    if (fin || stall !== 1'b1 || bus_req !== 1'b1) begin
      bad++; $display("FAIL no_timeout: done=%b stall=%b req=%b want 0/1/1", fin, stall, bus_req);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = '0;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_random;
    int st, rq, dly, kind, xr; bit e, sb, fin, mis, t, rdo, wro;
    logic w; logic [31:0] rd, a, wd, addr, d, ack, xd;
    int unsigned k;
    for (int n = 0; n < 40; n++) begin
      mis  = ($urandom_range(0, 6) == 0);
      addr = {$urandom_range(0, 31), 2'b00} + 32'h1000;
      if (mis) addr = addr + $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      rdo  = (kind != 1);
      wro  = (kind != 0);
      dly  = $urandom_range(1, 6);
      d    = $urandom;
      k    = addr >> 2;
      if (!mem.exists(k)) mem[k] = $urandom;
      ack  = wro ? $urandom : mem[k];
      run_access(rdo, wro, addr, d, ack, dly, 50,
                 st, rq, e, rd, sb, w, a, wd, fin);
      t  = exp_tmo(mis, dly);
      xr = exp_reqs(mis, dly);
      if (mis || t) xd = '0;
      else if (wro) xd = last_rdata;
      else xd = mem[k];
      total++;
      if (!fin || rq !== xr || st !== (mis ? 1 : xr + 1) || e !== (mis || t)) begin
        bad++; $display("FAIL rand_timing[%0d]: reqs=%0d stalls=%0d err=%b want %0d/%0d/%b",
                        n, rq, st, e, xr, mis ? 1 : xr + 1, mis || t);
      end
      total++;
      if (rd !== xd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, xd); end
      if (!mis) begin
        total++;
        if (!sb || w !== wro || a !== addr || (wro && wd !== d)) begin
          bad++; $display("FAIL rand_bus[%0d]: stable=%b we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                          n, sb, w, a, wd, wro, addr, d);
        end
      end
      if (!mis && !t && wro) mem[k] = d;
      last_rdata = xd;
      @(negedge clk);
      total++;
      if (stall !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rand_idle[%0d]: stall=%b err=%b want 0/0", n, stall, err); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_store_delayed();
    test_misaligned();
    test_stray_ack();
    test_both_strobes();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
